// File: rtl/fre_meter_bcd_pkg.sv
// fre_pkg: shared widths, limits, converter states and the double-dabble nibble adjust
package fre_pkg;
  localparam int BIN_W = 30;
  localparam int BCD_DIGITS = 9;
  localparam int BCD_W = 36;
  localparam int FRE_MAX = 999_999_999;
  typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} cv_state_t;
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < BCD_DIGITS; i++)
      r[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction
endpackage

// File: rtl/fre_meter_bcd_if.sv
// fre_meter_bcd_if: measured signal in, registered BCD frequency word out
interface fre_meter_bcd_if;
  import fre_pkg::*;
  logic sig_in;
  logic [BCD_W-1:0] fre_bcd;
  logic fre_vld;
  logic fre_ovf;
  modport master(input sig_in, output fre_bcd, fre_vld, fre_ovf);
  modport slave(output sig_in, input fre_bcd, fre_vld, fre_ovf);
endinterface

// File: rtl/fre_meter_bcd_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one shift per cycle, 30 shifts per conversion
module bin2bcd_seq
  import fre_pkg::*;
(
  input  logic             lcd_pclk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  cv_state_t state, state_n;
  logic [BIN_W-1:0] sh;
  logic [4:0] it;
  always_ff @(posedge lcd_pclk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= CV_IDLE;
      sh <= '0;
      bcd <= '0;
      it <= '0;
    end else begin
      state <= state_n;
      if (state == CV_IDLE && start) begin
        sh <= bin;
        bcd <= '0;
        it <= '0;
      end else if (state == CV_SHIFT) begin
        {bcd, sh} <= {add3(bcd), sh} << 1;
        it <= it + 5'd1;
      end
    end
  always_comb begin
    state_n = state;
    state_n = (state == CV_IDLE && start) ? CV_SHIFT :
              (state == CV_SHIFT && it == 5'd29) ? CV_DONE :
              (state == CV_DONE) ? CV_IDLE : state;
  end
  assign busy = state == CV_SHIFT;
  assign done = state == CV_DONE;
endmodule

// File: rtl/fre_meter_bcd.sv
// fre_meter_bcd: counts sig_in rising edges per gate window and reports them as packed BCD
module fre_meter_bcd
  import fre_pkg::*;
#(
  parameter int GATE_CYCLES = 33_000_000,
  parameter int MAX_COUNT = FRE_MAX
) (
  input logic lcd_pclk,
  input logic sys_rst_n,
  fre_meter_bcd_if.master bus
);
  localparam int GW = $clog2(GATE_CYCLES);
  logic s1, s2, hist, rise, close, start, busy, done, ovf_pend, fre_vld, fre_ovf;
  logic [GW-1:0] gcnt;
  logic [BIN_W-1:0] edge_cnt, cnt_inc, snap;
  logic [BCD_W-1:0] bcd, fre_bcd;
  assign rise = s2 & ~hist;
  assign close = gcnt == GW'(GATE_CYCLES - 1);
  // an edge in the closing cycle is folded into the snapshot, never the next window
  assign cnt_inc = edge_cnt + BIN_W'(rise & ~&edge_cnt);
  assign ovf_pend = snap > BIN_W'(MAX_COUNT);
  always_ff @(posedge lcd_pclk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      {s1, s2, hist} <= '0;
      gcnt <= '0;
      edge_cnt <= '0;
      snap <= '0;
      start <= 1'b0;
      fre_bcd <= '0;
      fre_vld <= 1'b0;
      fre_ovf <= 1'b0;
    end else begin
      {hist, s2, s1} <= {s2, s1, bus.sig_in};
      gcnt <= close ? '0 : gcnt + GW'(1);
      edge_cnt <= close ? '0 : cnt_inc;
      if (close) snap <= cnt_inc;
      start <= close & ~busy;
      fre_vld <= done;
      if (done) begin
        fre_bcd <= bcd;
        fre_ovf <= ovf_pend;
      end
    end
  bin2bcd_seq u_cv (
    .lcd_pclk (lcd_pclk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .bin      (ovf_pend ? BIN_W'(FRE_MAX) : snap),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd)
  );
  assign bus.fre_bcd = fre_bcd;
  assign bus.fre_vld = fre_vld;
  assign bus.fre_ovf = fre_ovf;
endmodule

// File: tb/tb_fre_meter_bcd.sv
// tb_fre_meter_bcd: directed scenarios on a 1000-cycle gate, plus a MAX_COUNT=99 instance
module tb_fre_meter_bcd;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig = 1'b0;
  int per = 0;
  int ph = 0;
  int checks = 0;
  int errors = 0;
  fre_meter_bcd_if b0 ();
  fre_meter_bcd_if b1 ();
  assign b0.sig_in = sig;
  assign b1.sig_in = sig;
  fre_meter_bcd #(.GATE_CYCLES(1000)) dut (.lcd_pclk(clk), .sys_rst_n(rst_n), .bus(b0.master));
  fre_meter_bcd #(.GATE_CYCLES(1000), .MAX_COUNT(99)) dut_s (.lcd_pclk(clk), .sys_rst_n(rst_n), .bus(b1.master));
  always #5 clk = ~clk;
  // period generator: high for per/2 cycles, low for the rest; idle when per == 0
  initial forever begin
    @(negedge clk);
    if (per != 0) begin
      ph = (ph + 1) % per;
      sig = ph < per / 2;
    end
  end
  task automatic wait_vld(output int n);
    n = 0;
    while (n < 1100) begin
      @(posedge clk);
      #1;
      n++;
      if (b0.fre_vld) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_vld: no fre_vld within %0d cycles, required within 1032", n);
  endtask
  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks += 4;
    if (b0.fre_bcd !== 36'h0) begin errors++; $display("FAIL reset_bcd: got %h, expected 0", b0.fre_bcd); end
    if (b0.fre_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b, expected 0", b0.fre_vld); end
    if (b0.fre_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, expected 0", b0.fre_ovf); end
    if (b1.fre_bcd !== 36'h0) begin errors++; $display("FAIL reset_bcd_s: got %h, expected 0", b1.fre_bcd); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_vld(n);
    checks += 2;
    if (n !== 1032) begin errors++; $display("FAIL first_vld_latency: got %0d cycles, expected 1032", n); end
    if (b0.fre_bcd !== 36'h0) begin errors++; $display("FAIL idle_bcd: got %h, expected 0", b0.fre_bcd); end
    wait_vld(n);
    checks += 2;
    if (n !== 1000) begin errors++; $display("FAIL vld_period: got %0d cycles, expected 1000", n); end
    if (b0.fre_bcd !== 36'h0) begin errors++; $display("FAIL idle_bcd2: got %h, expected 0", b0.fre_bcd); end
    @(posedge clk);
    #1;
    checks++;
    if (b0.fre_vld !== 1'b0) begin errors++; $display("FAIL vld_width: got %b one cycle later, expected 0", b0.fre_vld); end
  endtask
  task automatic test_period10;
    int n;
    per = 10;
    wait_vld(n);
    wait_vld(n);
    checks += 3;
    if (n !== 1000) begin errors++; $display("FAIL p10_period: got %0d cycles, expected 1000", n); end
    if (b0.fre_bcd !== 36'h0_0000_0100) begin errors++; $display("FAIL p10_bcd: got %h, expected 000000100", b0.fre_bcd); end
    if (b0.fre_ovf !== 1'b0) begin errors++; $display("FAIL p10_ovf: got %b, expected 0", b0.fre_ovf); end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (b0.fre_bcd !== 36'h0_0000_0100) begin errors++; $display("FAIL p10_hold: got %h, expected 000000100", b0.fre_bcd); end
  endtask
  task automatic test_fast;
    int n;
    per = 2;
    wait_vld(n);
    wait_vld(n);
    checks++;
    if (b0.fre_bcd !== 36'h0_0000_0500) begin errors++; $display("FAIL p2_bcd: got %h, expected 000000500", b0.fre_bcd); end
    per = 7;
    wait_vld(n);
    wait_vld(n);
    checks++;
    if (b0.fre_bcd !== 36'h0_0000_0142 && b0.fre_bcd !== 36'h0_0000_0143) begin
      errors++;
      $display("FAIL p7_bcd: got %h, expected 000000142 or 000000143", b0.fre_bcd);
    end
  endtask
  task automatic test_clamp;
    int n;
    per = 4;
    wait_vld(n);
    wait_vld(n);
    checks += 4;
    if (b1.fre_bcd !== 36'h9_9999_9999) begin errors++; $display("FAIL ovf_bcd: got %h, expected 999999999", b1.fre_bcd); end
    if (b1.fre_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", b1.fre_ovf); end
    if (b0.fre_bcd !== 36'h0_0000_0250) begin errors++; $display("FAIL p4_bcd: got %h, expected 000000250", b0.fre_bcd); end
    if (b0.fre_ovf !== 1'b0) begin errors++; $display("FAIL p4_ovf: got %b, expected 0", b0.fre_ovf); end
    per = 20;
    wait_vld(n);
    wait_vld(n);
    checks += 2;
    if (b1.fre_bcd !== 36'h0_0000_0050) begin errors++; $display("FAIL p20_bcd: got %h, expected 000000050", b1.fre_bcd); end
    if (b1.fre_ovf !== 1'b0) begin errors++; $display("FAIL p20_ovf: got %b, expected 0", b1.fre_ovf); end
  endtask
  task automatic test_close_edge;
    int n;
    per = 0;
    sig = 1'b0;
    wait_vld(n);
    wait_vld(n);
    checks++;
    if (b0.fre_bcd !== 36'h0) begin errors++; $display("FAIL quiet_bcd: got %h, expected 0", b0.fre_bcd); end
    // vld edge is close+32; rising at negedge after close+997 is detected in the closing cycle
    repeat (965) @(posedge clk);
    @(negedge clk);
    sig = 1'b1;
    wait_vld(n);
    checks++;
    if (b0.fre_bcd !== 36'h0_0000_0001) begin errors++; $display("FAIL close_edge_bcd: got %h, expected 000000001", b0.fre_bcd); end
    wait_vld(n);
    checks++;
    if (b0.fre_bcd !== 36'h0) begin errors++; $display("FAIL after_close_bcd: got %h, expected 0", b0.fre_bcd); end
    sig = 1'b0;
  endtask
  task automatic test_reset_mid;
    int n;
    bit seen;
    per = 10;
    wait_vld(n);
    wait_vld(n);
    seen = 1'b0;
    repeat (979) begin
      @(posedge clk);
      #1;
      if (b0.fre_vld) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL early_vld: got %b, expected 0", seen); end
    rst_n = 1'b0;
    per = 0;
    sig = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (b0.fre_vld) seen = 1'b1;
    end
    checks += 3;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_vld: got %b, expected 0", seen); end
    if (b0.fre_bcd !== 36'h0) begin errors++; $display("FAIL mid_reset_bcd: got %h, expected 0", b0.fre_bcd); end
    if (b0.fre_ovf !== 1'b0) begin errors++; $display("FAIL mid_reset_ovf: got %b, expected 0", b0.fre_ovf); end
    ph = 9;
    per = 10;
    @(negedge clk);
    rst_n = 1'b1;
    wait_vld(n);
    checks += 3;
    if (n !== 1032) begin errors++; $display("FAIL post_reset_latency: got %0d cycles, expected 1032", n); end
    if (b0.fre_bcd !== 36'h0_0000_0100) begin errors++; $display("FAIL post_reset_bcd: got %h, expected 000000100", b0.fre_bcd); end
    if (b0.fre_ovf !== 1'b0) begin errors++; $display("FAIL post_reset_ovf: got %b, expected 0", b0.fre_ovf); end
  endtask
  initial begin
    test_reset();
    test_period10();
    test_fast();
    test_clamp();
    test_close_edge();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fre_meter_bcd.md
# fre_meter_bcd

Frequency meter that produces the 9-digit packed-BCD frequency word consumed by the oscilloscope's on-screen frequency readout. It counts rising edges of a digitised input signal over a fixed gate window of `lcd_pclk` cycles. Each window's count is converted to BCD with a sequential double-dabble engine, and the result is held stable on `fre_bcd` between updates. It sits between the trigger/comparator front end and the display path, in the `lcd_pclk` domain, so no clock-domain crossing is needed on the output.

## Interface
- `GATE_CYCLES`, default 33_000_000: gate window length in `lcd_pclk` cycles. 1 s at the default clock gives 1 Hz resolution. Must be ≥ 64.
- `MAX_COUNT`, default 999_999_999: largest reportable count. Set it lower only for simulation.
- `lcd_pclk` input 1: single clock; all logic runs on its rising edge.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `sig_in` input 1: measured signal, asynchronous to `lcd_pclk`.
- `fre_bcd` output 36: packed BCD, digit 8 in [35:32] down to digit 0 in [3:0]. Registered.
- `fre_vld` output 1: one-cycle pulse when `fre_bcd` updates.
- `fre_ovf` output 1: set when the latched count exceeded `MAX_COUNT`. Updates together with `fre_bcd`.

## Operation
- **Input synchronisation:** `sig_in` passes through a 2-flop synchroniser plus one history flop. A rising edge is detected when the synchronised value is 1 and the history flop is 0.
- **Gate counter:** free-running from 0 to `GATE_CYCLES`-1, then wraps to 0.
- **Edge counter:** 30-bit `edge_cnt`. It increments on each detected edge and saturates at 2^30-1.
- **Window close** (gate counter == `GATE_CYCLES`-1):
  - `snap` ← `edge_cnt` plus the edge detected in that same cycle, saturating.
  - `edge_cnt` ← 0.
  - An edge in the closing cycle belongs to the closing window, never the next one.
- **Range clamp:** if `snap` > `MAX_COUNT`, the converter input is 999_999_999 and `ovf_pend` = 1. Otherwise the input is `snap` and `ovf_pend` = 0. The display path ignores words whose digit 8 is non-zero, so an overflow reading (36'h9_9999_9999) is suppressed there.
- **Converter FSM:**
  - States: CV_IDLE → CV_SHIFT → CV_DONE → CV_IDLE.
  - CV_IDLE: waits for window close; loads the 30-bit binary register and clears the 36-bit BCD register.
  - CV_SHIFT: runs 30 iterations, one per cycle. In each iteration, every BCD nibble ≥ 5 gets +3, then {bcd, bin} is shifted left by 1.
  - CV_DONE: `fre_bcd` ← bcd, `fre_ovf` ← `ovf_pend`, `fre_vld` = 1. Then returns to CV_IDLE.
  - A window close cannot occur outside CV_IDLE because `GATE_CYCLES` ≥ 64 exceeds the 32-cycle conversion.
- **Edge counting during conversion:** counting continues uninterrupted; the conversion works only on the snapshot.
- **Reset values:** `fre_bcd` = 0, `fre_vld` = 0, `fre_ovf` = 0; all counters = 0; FSM = CV_IDLE; synchroniser flops = 0.
- **Reset mid-operation:** asserting reset aborts any conversion with no `fre_vld`. After release, the first update follows the first full window.

## Timing
- `sig_in` to counted edge: 3 cycles (2 synchroniser + 1 detect).
- Window close to output: the close edge registers `snap`. CV_SHIFT occupies the next 30 cycles. `fre_bcd`/`fre_vld` update on the 32nd rising edge after the close edge.
- `fre_vld` is high for exactly 1 cycle, once per `GATE_CYCLES`.
- `fre_bcd` holds its value between pulses.
- Maximum measurable frequency: `lcd_pclk`/2. Higher frequencies alias.
- First `fre_vld` after reset: `GATE_CYCLES` + 31 cycles after the first post-reset edge.

## Structure
- Package `fre_pkg` holds:
  - `BIN_W` = 30
  - `BCD_DIGITS` = 9
  - `BCD_W` = 36
  - `FRE_MAX` = 999_999_999
  - the converter FSM state enum.
- Sub-module `bin2bcd_seq`: the double-dabble engine.
  - Ports: start, `bin[29:0]`, busy, done, `bcd[35:0]`.
  - Same clock and reset as this block.
- The top level holds the synchroniser, gate counter, edge counter and range clamp.

## Test plan
All scenarios use `GATE_CYCLES` = 1000 unless stated.
1. Reset held → `fre_bcd` = 0, `fre_vld` = 0, `fre_ovf` = 0. Release with `sig_in` = 0 → `fre_bcd` = 0 at every update, one `fre_vld` per 1000 cycles.
2. `sig_in` period 10 clocks → `fre_bcd` = 36'h0_0000_0100, `fre_ovf` = 0. The 32-cycle close-to-`fre_vld` latency is checked.
3. `sig_in` toggling every cycle (period 2) → `fre_bcd` = 36'h0_0000_0500. Then `sig_in` period 7 → the next full window reads 36'h0_0000_0142 or 36'h0_0000_0143, depending on phase.
4. `MAX_COUNT` = 99, `sig_in` period 4 (250 edges) → `fre_bcd` = 36'h9_9999_9999, `fre_ovf` = 1. Then period 20 (50 edges) → 36'h0_0000_0050, `fre_ovf` = 0.
5. Single edge placed in the closing cycle of a window → counted in that window (value 1); the following empty window reads 0.
6. Reset pulsed 10 cycles into CV_SHIFT → no `fre_vld`, outputs remain 0. The first update arrives one full window after release with the correct count.
